// File: rtl/display_scanout_if.sv
// Scan-out bus: frame-buffer read port, host swap handshake and display PHY outputs.
// master = scan-out engine, slave = its environment (buffers, writer, PHY).
interface display_scanout_if #(
    parameter int ADDR_W = 20
);
    logic              enable;
    logic              swap_req;
    logic              swap_ack;
    logic              disp_sel;
    logic              re0;
    logic              re1;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        r0, b0, g0;
    logic [7:0]        r1, b1, g1;
    logic [7:0]        pix_r, pix_g, pix_b;
    logic              de;
    logic              hsync;
    logic              vsync;
    logic              frame_start;

    modport master (
        input  enable, swap_req, r0, b0, g0, r1, b1, g1,
        output swap_ack, disp_sel, re0, re1, addr,
               pix_r, pix_g, pix_b, de, hsync, vsync, frame_start
    );

    modport slave (
        output enable, swap_req, r0, b0, g0, r1, b1, g1,
        input  swap_ack, disp_sel, re0, re1, addr,
               pix_r, pix_g, pix_b, de, hsync, vsync, frame_start
    );
endinterface

// File: rtl/display_scanout.sv
// Raster scan-out engine: ping-pong frame-buffer reader with raster timing and
// frame-boundary buffer swaps; one register stage between issue and display.
module display_scanout #(
    parameter int H_ACTIVE = 100,
    parameter int H_FP     = 4,
    parameter int H_SYNC   = 8,
    parameter int H_BP     = 4,
    parameter int V_ACTIVE = 100,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 2,
    parameter int ADDR_W   = 20
) (
    input  logic              clk,
    input  logic              reset,
    display_scanout_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            r_state;
    logic [HW-1:0]     r_h;
    logic [VW-1:0]     r_v;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_hold;
    logic              r_sel, r_pend, r_ack;
    logic              r_de, r_hs, r_vs, r_fs, r_sel_d;

    logic              w_scan, w_active, w_boundary, w_start, w_swap;
    logic              w_hs, w_vs, w_fs;
    logic [23:0]       w_pix;

    assign w_scan     = (r_state == SCAN);
    assign w_active   = w_scan && (r_h < H_ACT) && (r_v < V_ACT);
    assign w_boundary = w_scan && (r_h == H_LAST) && (r_v == V_LAST);
    assign w_start    = (r_state == IDLE) && bus.enable;
    // A request arriving on the boundary cycle itself is honoured there.
    assign w_swap     = (w_boundary || w_start) && (r_pend || bus.swap_req);
    assign w_hs       = w_scan && (r_h >= HS_BEG) && (r_h < HS_END);
    assign w_vs       = w_scan && (r_v >= VS_BEG) && (r_v < VS_END);
    assign w_fs       = w_scan && (r_h == '0) && (r_v == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_h     <= '0;
            r_v     <= '0;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_sel   <= 1'b0;
            r_pend  <= 1'b0;
            r_ack   <= 1'b0;
            r_de    <= 1'b0;
            r_hs    <= 1'b0;
            r_vs    <= 1'b0;
            r_fs    <= 1'b0;
            r_sel_d <= 1'b0;
        end else begin
            r_ack <= w_swap;
            if (w_swap) begin
                r_sel  <= ~r_sel;
                r_pend <= 1'b0;
            end else if (bus.swap_req) begin
                r_pend <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_h <= '0;
                    r_v <= '0;
                    if (bus.enable) r_state <= SCAN;
                end
                SCAN: begin
                    // r_hold keeps the last issued address visible during blanking.
                    if (w_active) begin
                        r_hold <= r_cnt;
                        r_cnt  <= r_cnt + ADDR_W'(1);
                    end
                    if (r_h == H_LAST) begin
                        r_h <= '0;
                        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
                    end else begin
                        r_h <= r_h + 1'b1;
                    end
                    if (w_boundary) begin
                        r_cnt  <= '0;
                        r_hold <= '0;
                        if (!bus.enable) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            r_de    <= w_active;
            r_hs    <= w_hs;
            r_vs    <= w_vs;
            r_fs    <= w_fs;
            r_sel_d <= r_sel;
        end
    end

    assign bus.re0      = w_active && !r_sel;
    assign bus.re1      = w_active &&  r_sel;
    assign bus.addr     = w_active ? r_cnt : r_hold;
    assign bus.swap_ack = r_ack;
    assign bus.disp_sel = r_sel;

    // Buffer data arrives one cycle after re, lining up with the delayed de.
    assign w_pix = !r_de   ? 24'd0 :
                   r_sel_d ? {bus.g1, bus.b1, bus.r1} : {bus.g0, bus.b0, bus.r0};

    assign bus.pix_r       = w_pix[7:0];
    assign bus.pix_b       = w_pix[15:8];
    assign bus.pix_g       = w_pix[23:16];
    assign bus.de          = r_de;
    assign bus.hsync       = r_hs;
    assign bus.vsync       = r_vs;
    assign bus.frame_start = r_fs;
endmodule
